lane_merge_arb: RTL and testbench

// - Downstream consumer of the 1-to-2 byte dispatcher: drains its two 8-bit lane FIFOs and merges them into one byte stream with a lane tag.
// - Issues per-lane pops. Arbitration is almost-full-priority first, then round-robin with bounded bursts.
// - Output stage is 2-entry credit-checked. It never overflows and never pops an empty FIFO.

---
 rtl/lane_pkg.sv | 16 +
 rtl/skid_buf2.sv | 63 ++++++
 rtl/lane_merge_arb.sv | 137 +++++++++++++
 tb/tb_lane_merge_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared definitions for the lane merge arbiter: lane encodings, arbiter
// states and default widths.
package lane_pkg;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic {
        GRANT0 = 1'b0,
        GRANT1 = 1'b1
    } arb_state_t;

endpackage : lane_pkg

// File: rtl/skid_buf2.sv
// Two-entry {lane, byte} FIFO used as the merge output stage. The head
// entry is presented combinationally; outputs read as zero while empty.
module skid_buf2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_push_lane,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic              o_lane,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occ
);

    logic [DATA_W-1:0] r_data [2];
    logic [1:0]        r_lane;
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_occ;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_occ != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_occ != 2'd2) || w_do_pop);

    // Pointer and occupancy bookkeeping; 1-bit pointers wrap naturally over two slots.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (w_do_push) r_tail <= ~r_tail;
            if (w_do_pop)  r_head <= ~r_head;
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Entry storage; contents are qualified by occupancy, so the array needs no reset.
    // NOTE: leaving the storage array out of reset keeps it plain RAM; o_valid gates any stale data.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_data[r_tail] <= i_push_data;
            r_lane[r_tail] <= i_push_lane;
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_data  = o_valid ? r_data[r_head] : '0;
    assign o_lane  = o_valid && r_lane[r_head];
    assign o_occ   = r_occ;

endmodule : skid_buf2

// File: rtl/lane_merge_arb.sv
// Merges two lane FIFOs into one tagged byte stream. Pops are registered
// and credit-checked against a 2-entry output buffer; arbitration favours a
// single almost-full lane, otherwise round-robins with bounded bursts.
module lane_merge_arb
    import lane_pkg::*;
#(
    parameter int DATA_W    = lane_pkg::DATA_W,
    parameter int MAX_BURST = lane_pkg::MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              almost_full0,
    input  logic              almost_full1,
    input  logic              out_ready,
    output logic              pop0,
    output logic              pop1,
    output logic [DATA_W-1:0] data_out,
    output logic              lane_out,
    output logic              valid_out
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic [3:0] r_burst;
    logic [3:0] w_burst_next;
    logic       r_pop0;
    logic       r_pop1;
    logic       w_pop0_next;
    logic       w_pop1_next;

    logic              w_inflight;
    logic [DATA_W-1:0] w_push_data;
    logic              w_accept;
    logic [1:0]        w_occ;
    logic [2:0]        w_occ_next;
    logic              w_credit_ok;

    logic       w_cur_lane;
    logic       w_cur_empty;
    logic       w_oth_empty;
    logic       w_urgent0;
    logic       w_urgent1;
    logic [3:0] w_burst_inc;
    logic       w_cand_valid;
    logic       w_cand_lane;
    logic [3:0] w_cand_burst;

    // A pop strobe issued last edge means its byte is on data_inX now.
    assign w_inflight  = r_pop0 || r_pop1;
    assign w_push_data = r_pop1 ? data_in1 : data_in0;
    assign w_accept    = valid_out && out_ready;

    skid_buf2 #(.DATA_W(DATA_W)) u_out_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_inflight),
        .i_push_lane (r_pop1),
        .i_push_data (w_push_data),
        .i_pop       (w_accept),
        .o_valid     (valid_out),
        .o_lane      (lane_out),
        .o_data      (data_out),
        .o_occ       (w_occ)
    );

    // Occupancy after this edge; a new pop is allowed only if its byte will still fit.
    assign w_occ_next  = {1'b0, w_occ} + {2'b00, w_inflight} - {2'b00, w_accept};
    assign w_credit_ok = (w_occ_next <= 3'd1);

    assign w_cur_lane  = (r_state == GRANT1);
    assign w_cur_empty = w_cur_lane ? empty1 : empty0;
    assign w_oth_empty = w_cur_lane ? empty0 : empty1;
    assign w_urgent0   = almost_full0 && !almost_full1 && !empty0;
    assign w_urgent1   = almost_full1 && !almost_full0 && !empty1;
    assign w_burst_inc = (r_burst >= MAX_B) ? MAX_B : r_burst + 4'd1;

    // Candidate lane selection and next arbiter state.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_cand_valid = 1'b0;
        w_cand_lane  = w_cur_lane;
        w_cand_burst = r_burst;
        w_state_next = r_state;
        w_burst_next = r_burst;
        w_pop0_next  = 1'b0;
        w_pop1_next  = 1'b0;

        if (w_urgent0 || w_urgent1) begin
            w_cand_valid = 1'b1;
            w_cand_lane  = w_urgent1 ? LANE1 : LANE0;
            w_cand_burst = (w_cand_lane == w_cur_lane) ? w_burst_inc : 4'd1;
        end else if (!w_cur_empty && (r_burst < MAX_B)) begin
            w_cand_valid = 1'b1;
            w_cand_burst = w_burst_inc;
        end else if (!w_oth_empty) begin
            w_cand_valid = 1'b1;
            w_cand_lane  = !w_cur_lane;
            w_cand_burst = 4'd1;
        end else if (!w_cur_empty) begin
            // Other lane idle: burst restarts and this pop counts as its first grant.
            w_cand_valid = 1'b1;
            w_cand_burst = 4'd1;
        end

        if (w_cand_valid && w_credit_ok) begin
            w_pop0_next  = (w_cand_lane == LANE0);
            w_pop1_next  = (w_cand_lane == LANE1);
            w_state_next = (w_cand_lane == LANE1) ? GRANT1 : GRANT0;
            w_burst_next = w_cand_burst;
        end
    end

    // Arbiter state, burst counter and registered pop strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= GRANT0;
            r_burst <= 4'd0;
            r_pop0  <= 1'b0;
            r_pop1  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_burst <= w_burst_next;
            r_pop0  <= w_pop0_next;
            r_pop1  <= w_pop1_next;
        end
    end

    assign pop0 = r_pop0;
    assign pop1 = r_pop1;

endmodule : lane_merge_arb

// File: tb/tb_lane_merge_arb.sv
// Scoreboard bench for lane_merge_arb: directed scenarios push hand-computed
// output bytes into a queue; a negedge monitor pops and compares each accept.
module tb_lane_merge_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in0, data_in1;
    logic       empty0, empty1, almost_full0, almost_full1, out_ready;
    logic       pop0, pop1, lane_out, valid_out;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    lane_merge_arb #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in0     (data_in0),
        .data_in1     (data_in1),
        .empty0       (empty0),
        .empty1       (empty1),
        .almost_full0 (almost_full0),
        .almost_full1 (almost_full1),
        .out_ready    (out_ready),
        .pop0         (pop0),
        .pop1         (pop1),
        .data_out     (data_out),
        .lane_out     (lane_out),
        .valid_out    (valid_out)
    );

    typedef struct packed {
        logic       lane;
        logic [7:0] data;
    } exp_t;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    exp_t       exp_q[$];

    int checks = 0;
    int errors = 0;
    int pops0_cnt = 0;
    int pops1_cnt = 0;
    int cyc = 0;
    int n_acc = 0;
    int first_acc = 0;
    int last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane FIFO model: show-ahead data; empty already accounts for the pop
    // currently being strobed, so a single remaining byte is never popped twice.
    task automatic refresh();
        empty0   = (q0.size() == 0) || (q0.size() == 1 && pop0 === 1'b1);
        empty1   = (q1.size() == 0) || (q1.size() == 1 && pop1 === 1'b1);
        data_in0 = (q0.size() > 0) ? q0[0] : 8'h00;
        data_in1 = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    task automatic tick();
        logic p0, p1;
        @(negedge clk);
        p0 = (pop0 === 1'b1);
        p1 = (pop1 === 1'b1);
        check("pop_exclusive", {31'b0, p0 && p1}, 32'd0);
        @(posedge clk);
        #1;
        if (p0) begin
            pops0_cnt++;
            check("pop0_nonempty", q0.size(), (q0.size() > 0) ? q0.size() : 1);
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (p1) begin
            pops1_cnt++;
            check("pop1_nonempty", q1.size(), (q1.size() > 0) ? q1.size() : 1);
            if (q1.size() > 0) void'(q1.pop_front());
        end
        refresh();
    endtask

    task automatic load(input int lane, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (lane == 0) q0.push_back(base + 8'(i));
            else           q1.push_back(base + 8'(i));
        end
    endtask

    task automatic push_exp(input logic lane, input logic [7:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.lane = lane;
            e.data = base + 8'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        out_ready    = 1'b0;
        almost_full0 = 1'b0;
        almost_full1 = 1'b0;
        tick();
        tick();
        q0.delete();
        q1.delete();
        exp_q.delete();
        refresh();
        reset     = 1'b1;
        pops0_cnt = 0;
        pops1_cnt = 0;
        n_acc     = 0;
    endtask

    // Monitor: every accepted output must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1 && valid_out === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {24'b0, data_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", {24'b0, data_out}, {24'b0, e.data});
                    check("lane_out", {31'b0, lane_out}, {31'b0, e.lane});
                end
                n_acc++;
                if (n_acc == 1) first_acc = cyc;
                last_acc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        out_ready    = 1'b1;
        almost_full0 = 1'b0;
        almost_full1 = 1'b0;
        load(0, 8'h01, 3);
        load(1, 8'h04, 2);
        refresh();

        // Reset held with both lanes non-empty: nothing pops, nothing valid.
        repeat (3) begin
            tick();
            check("rst_pop0", {31'b0, pop0}, 32'd0);
            check("rst_pop1", {31'b0, pop1}, 32'd0);
            check("rst_valid", {31'b0, valid_out}, 32'd0);
            check("rst_data", {24'b0, data_out}, 32'd0);
        end

        // Round-robin, bursts of 4, full rate.
        do_reset();
        out_ready = 1'b1;
        load(0, 8'h10, 8);
        load(1, 8'h20, 8);
        push_exp(1'b0, 8'h10, 4);
        push_exp(1'b1, 8'h20, 4);
        push_exp(1'b0, 8'h14, 4);
        push_exp(1'b1, 8'h24, 4);
        refresh();
        repeat (24) tick();
        check("rr_drain", exp_q.size(), 32'd0);
        check("rr_count", n_acc, 32'd16);
        check("rr_rate", last_acc - first_acc, 32'd15);

        // Urgency: almost_full1 seen at the third decision preempts lane0.
        do_reset();
        out_ready = 1'b1;
        load(0, 8'h30, 6);
        load(1, 8'h40, 1);
        push_exp(1'b0, 8'h30, 2);
        push_exp(1'b1, 8'h40, 1);
        push_exp(1'b0, 8'h32, 4);
        refresh();
        tick();
        tick();
        almost_full1 = 1'b1;
        tick();
        almost_full1 = 1'b0;
        repeat (12) tick();
        check("urg_drain", exp_q.size(), 32'd0);
        check("urg_pops1", pops1_cnt, 32'd1);
        check("urg_pops0", pops0_cnt, 32'd6);

        // Backpressure: buffer fills to 2 and pops stop until out_ready returns.
        do_reset();
        out_ready = 1'b0;
        load(0, 8'h50, 6);
        push_exp(1'b0, 8'h50, 6);
        refresh();
        repeat (5) tick();
        check("bp_pops", pops0_cnt, 32'd2);
        check("bp_pop_now", {31'b0, pop0}, 32'd0);
        check("bp_valid", {31'b0, valid_out}, 32'd1);
        check("bp_hold_data", {24'b0, data_out}, 32'h50);
        check("bp_hold_lane", {31'b0, lane_out}, 32'd0);
        out_ready = 1'b1;
        repeat (12) tick();
        check("bp_drain", exp_q.size(), 32'd0);
        check("bp_total_pops", pops0_cnt, 32'd6);

        // Empty boundary: a single byte yields exactly one pop.
        do_reset();
        out_ready = 1'b1;
        load(0, 8'h60, 1);
        push_exp(1'b0, 8'h60, 1);
        refresh();
        repeat (6) tick();
        check("empty_pops0", pops0_cnt, 32'd1);
        check("empty_pops1", pops1_cnt, 32'd0);
        check("empty_valid", {31'b0, valid_out}, 32'd0);
        check("empty_drain", exp_q.size(), 32'd0);

        // Mid-operation reset with a pop in flight and a byte buffered.
        do_reset();
        out_ready = 1'b1;
        load(0, 8'h70, 8);
        load(1, 8'h80, 8);
        push_exp(1'b0, 8'h70, 1);
        refresh();
        repeat (3) tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        tick();
        check("mid_rst_valid", {31'b0, valid_out}, 32'd0);
        check("mid_rst_pop0", {31'b0, pop0}, 32'd0);
        check("mid_rst_pop1", {31'b0, pop1}, 32'd0);
        check("mid_rst_data", {24'b0, data_out}, 32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        push_exp(1'b0, 8'h73, 4);
        push_exp(1'b1, 8'h80, 4);
        push_exp(1'b0, 8'h77, 1);
        push_exp(1'b1, 8'h84, 4);
        refresh();
        tick();
        check("restart_pop0", {31'b0, pop0}, 32'd1);
        check("restart_pop1", {31'b0, pop1}, 32'd0);
        repeat (19) tick();
        check("mid_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lane_merge_arb
